// File: rtl/mips_md_pkg.sv
// Shared encodings and constants for the MIPS32 iterative multiply/divide unit.
package mips_md_pkg;

    localparam int DATA_W  = 32;
    localparam int MD_ITER = 32;

    // 6 and 7 are reserved and have no encoding here.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO writes.
// One result bit per clock; a single 65-bit working register serves both operations.
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] In1,
    input  logic [DATA_W-1:0] In2,
    input  logic [2:0]        OP,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);
    import mips_md_pkg::*;

    localparam int W2 = 2 * DATA_W;

    md_state_e         state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              sgn_res_q, sgn_res_d;
    logic              sgn_rem_q, sgn_rem_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [W2:0]       work_q, work_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              is_signed, a_neg, b_neg;
    logic [DATA_W-1:0] a_abs, b_abs;
    logic              is_div;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W+1:0] trial;
    logic [W2:0]       mul_next, div_next;
    logic [W2-1:0]     prod, prod_fix;
    logic [DATA_W-1:0] quo_fix, rem_fix;

    // Operand conditioning; |0x80000000| stays 0x80000000 and is treated as unsigned.
    always_comb begin
        is_signed = (OP == MD_MULT) || (OP == MD_DIV);
        a_neg     = is_signed & In1[DATA_W-1];
        b_neg     = is_signed & In2[DATA_W-1];
        a_abs     = a_neg ? -In1 : In1;
        b_abs     = b_neg ? -In2 : In2;
    end

    // Datapath for one iteration: shift-add for multiply, restoring step for divide.
    always_comb begin
        is_div   = (op_q == MD_DIV) || (op_q == MD_DIVU);
        mul_sum  = {1'b0, work_q[W2-1:DATA_W]} + (work_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {1'b0, mul_sum, work_q[DATA_W-1:1]};
        rem_sh   = {work_q[W2-1:DATA_W], work_q[DATA_W-1]};
        trial    = {1'b0, rem_sh} - {2'b00, opb_q};
        div_next = trial[DATA_W+1] ? {rem_sh, work_q[DATA_W-2:0], 1'b0}
                                   : {trial[DATA_W:0], work_q[DATA_W-2:0], 1'b1};
    end

    // Sign fix, only consumed in FIN. A zero divisor leaves the dividend magnitude
    // in the remainder, so re-applying the dividend sign restores In1 bit-exactly.
    always_comb begin
        prod     = work_q[W2-1:0];
        prod_fix = sgn_res_q ? -prod : prod;
        quo_fix  = (opb_q == '0) ? '1
                 : (sgn_res_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0]);
        rem_fix  = sgn_rem_q ? -work_q[W2-1:DATA_W] : work_q[W2-1:DATA_W];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sgn_res_d = sgn_res_q;
        sgn_rem_d = sgn_rem_q;
        opb_d     = opb_q;
        work_d    = work_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (OP)
                        MD_MULT, MD_MULTU: begin
                            opb_d  = a_abs;
                            work_d = {{(DATA_W+1){1'b0}}, b_abs};
                        end
                        MD_DIV, MD_DIVU: begin
                            opb_d  = b_abs;
                            work_d = {{(DATA_W+1){1'b0}}, a_abs};
                        end
                        MD_MTHI: hi_d = In1;
                        MD_MTLO: lo_d = In1;
                        default: ;
                    endcase
                    if (OP <= MD_DIVU) begin
                        op_d      = OP;
                        sgn_res_d = a_neg ^ b_neg;
                        sgn_rem_d = a_neg;
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                work_d = is_div ? div_next : mul_next;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'(MD_ITER - 1)) state_d = S_FIN;
            end
            S_FIN: begin
                if (is_div) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[W2-1:DATA_W];
                    lo_d = prod_fix[DATA_W-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            sgn_res_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            opb_q     <= '0;
            work_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            sgn_res_q <= sgn_res_d;
            sgn_rem_q <= sgn_rem_d;
            opb_q     <= opb_d;
            work_q    <= work_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: results, latency, MTHI/MTLO and reset abort.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic [31:0] In1, In2;
    logic [2:0]  OP;
    logic        start;
    logic        busy, done;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_bad = 0;

    mult_div_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .In1(In1), .In2(In2), .OP(OP), .start(start),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; start is sampled at the following rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        OP = op; In1 = a; In2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called right after issue(); counts busy cycles until done (bounded).
    task automatic wait_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int nbusy = 0;
        int guard = 0;
        while (!done && guard < 100) begin
            if (busy) nbusy++;
            guard++;
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(nbusy), 32'd33);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        int guard;
        int seen_done;
        rst = 1'b1; start = 1'b0; OP = '0; In1 = '0; In2 = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        // start during the done cycle must be accepted
        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        @(negedge clk);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg_dvd", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        @(negedge clk);
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_neg_dvs", 32'd1, 32'hFFFF_FFFD);
        @(negedge clk);
        issue(3'd3, 32'd100, 32'd7);
        wait_done("divu", 32'd2, 32'd14);
        @(negedge clk);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 32'd0, 32'h8000_0000);
        @(negedge clk);
        issue(3'd3, 32'd5, 32'd0);
        wait_done("divu_zero", 32'd5, 32'hFFFF_FFFF);

        @(negedge clk);
        issue(3'd4, 32'h1234_5678, 32'd0);
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_lo_keep", LO, 32'hFFFF_FFFF);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_done", 32'(done), 32'd0);
        issue(3'd5, 32'hCAFE_F00D, 32'd0);
        chk("mtlo_lo", LO, 32'hCAFE_F00D);
        chk("mtlo_done", 32'(done), 32'd0);
        issue(3'd6, 32'hAAAA_AAAA, 32'd1);
        chk("rsvd_busy", 32'(busy), 32'd0);
        chk("rsvd_hi", HI, 32'h1234_5678);
        chk("rsvd_lo", LO, 32'hCAFE_F00D);

        // MTLO while RUN is ignored; HI/LO stay stale during the operation
        issue(3'd3, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        issue(3'd5, 32'hDEAD_BEEF, 32'd0);
        chk("run_mtlo_lo", LO, 32'hCAFE_F00D);
        chk("run_stale_hi", HI, 32'h1234_5678);
        chk("run_busy", 32'(busy), 32'd1);
        guard = 0;
        while (!done && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        chk("run_mtlo_done", 32'(done), 32'd1);
        chk("run_mtlo_hi", HI, 32'd2);
        chk("run_mtlo_lo_final", LO, 32'd14);

        // asynchronous reset after 10 iterations
        @(negedge clk);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        issue(3'd1, 32'd3, 32'd5);
        wait_done("multu_after_rst", 32'd0, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
